id_ex_pipe_ctrl: RTL and testbench

Parametrised ID/EX pipeline register for the RISC-V core, sitting between the decode stage (register file, immediate generator, control unit) and the execute stage (ALU, forwarding unit). It adds a valid bit, downstream stall, branch flush and built-in load-use hazard detection with bubble insertion. It also keeps a saturating bubble counter for performance debug.

---
 rtl/rv_pipe_pkg.sv | 31 +++
 rtl/load_use_detect.sv | 30 +++
 rtl/id_ex_pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_id_ex_pipe_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_pipe_pkg
// Brief   : Shared defaults, control-bundle bit positions and ALUOp codes
// Revision: 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

    localparam int DEF_XLEN   = 64;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_CTRL_W = 8;

    // Control bundle layout, MSB first
    localparam int CTRL_MEMTOREG  = 7;
    localparam int CTRL_REGWRITE  = 6;
    localparam int CTRL_BRANCH    = 5;
    localparam int CTRL_MEMWRITE  = 4;
    localparam int CTRL_MEMREAD   = 3;
    localparam int CTRL_ALUSRC    = 2;
    localparam int CTRL_ALUOP_MSB = 1;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef enum logic [1:0] {
        ALUOP_LDST   = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module  : load_use_detect
// Brief   : Combinational load-use hazard check between EX and ID slots
// Revision: 1.0 - initial release
// ============================================================================
module load_use_detect
    import rv_pipe_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    output logic             o_lu
);

    logic w_rd_match;

    // x0 is hardwired to zero, so a load into it never produces a dependency
    assign w_rd_match = (i_ex_rd != '0) &&
                        ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

    assign o_lu = i_ex_valid & i_ex_memread & i_id_valid & w_rd_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_pipe_ctrl
// Brief   : ID/EX pipeline register with stall, flush, load-use bubbles
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_pipe_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_W  = DEF_REG_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [3:0]        id_funct4,
    input  logic [2:0]        id_funct3,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [3:0]        ex_funct4,
    output logic [2:0]        ex_funct3,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [3:0]        r_funct4;
    logic [2:0]        r_funct3;
    logic [REG_W-1:0]  r_rd, r_rs1, r_rs2;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic w_lu;
    logic w_clear;
    logic w_bubble;
    logic w_load;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_lu (
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_ctrl[CTRL_MEMREAD]),
        .i_ex_rd      (r_rd),
        .i_id_valid   (id_valid),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .o_lu         (w_lu)
    );

    // Priority: flush > ex_stall > load-use bubble > capture
    assign w_bubble = ~flush & ~ex_stall & w_lu;
    assign w_clear  = flush | w_bubble;
    assign w_load   = ~flush & ~ex_stall & ~w_lu;

    assign hazard_stall = ~flush & (ex_stall | w_lu);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_funct4     <= '0;
            r_funct3     <= '0;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_ctrl       <= '0;
            r_bubble_cnt <= '0;
        end else if (w_clear) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_funct4   <= '0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_ctrl     <= '0;
            if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (w_load) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_funct4   <= id_funct4;
            r_funct3   <= id_funct3;
            r_rd       <= id_rd;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            // An empty decode slot must not carry stray write enables into EX
            r_ctrl     <= id_valid ? id_ctrl : '0;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_funct4    = r_funct4;
    assign ex_funct3    = r_funct3;
    assign ex_rd        = r_rd;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_ctrl      = r_ctrl;
    assign bubble_count = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_pipe_ctrl
// Brief   : Self-checking bench: vector table plus scoreboard queue
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_ctrl;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;
    localparam int CNT_W = 2;
    localparam logic [7:0] C_ADD = 8'b0100_0010;
    localparam logic [7:0] C_LD  = 8'b1100_1100;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]       id_funct4;
    logic [2:0]       id_funct3;
    logic [REG_W-1:0] id_rd, id_rs1, id_rs2;
    logic [7:0]       id_ctrl;
    logic             ex_stall, flush;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [3:0]       ex_funct4;
    logic [2:0]       ex_funct3;
    logic [REG_W-1:0] ex_rd, ex_rs1, ex_rs2;
    logic [7:0]       ex_ctrl;
    logic             hazard_stall;
    logic [CNT_W-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_pipe_ctrl #(
        .XLEN(XLEN), .REG_W(REG_W), .CTRL_W(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_funct4(id_funct4), .id_funct3(id_funct3),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ctrl(id_ctrl),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_funct4(ex_funct4),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    typedef struct {
        logic             v;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd, rs1, rs2;
        logic [7:0]       ctrl;
        logic             fl, st, hz;
    } stim_t;

    typedef struct {
        logic             v;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd, rs1, rs2;
        logic [7:0]       ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    // Data payloads are derived from the PC so that pc==0 implies all zero
    function automatic logic [XLEN-1:0] rs1d(input logic [XLEN-1:0] pc); return pc << 4;  endfunction
    function automatic logic [XLEN-1:0] rs2d(input logic [XLEN-1:0] pc); return pc << 8;  endfunction
    function automatic logic [XLEN-1:0] immd(input logic [XLEN-1:0] pc); return pc << 12; endfunction

    function automatic vec_t row(input logic v, input logic [XLEN-1:0] pc,
                                 input logic [REG_W-1:0] rd, rs1, rs2, input logic [7:0] ctrl,
                                 input logic fl, st, hz, input logic ev, input logic [XLEN-1:0] epc,
                                 input logic [REG_W-1:0] erd, ers1, ers2, input logic [7:0] ectrl,
                                 input logic [CNT_W-1:0] ecnt);
        vec_t r;
        r.s = '{v, pc, rd, rs1, rs2, ctrl, fl, st, hz};
        r.e = '{ev, epc, erd, ers1, ers2, ectrl, ecnt};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, " ex_valid"},     XLEN'(ex_valid),     XLEN'(e.v));
        chk({tag, " ex_pc"},        ex_pc,               e.pc);
        chk({tag, " ex_rs1_data"},  ex_rs1_data,         rs1d(e.pc));
        chk({tag, " ex_rs2_data"},  ex_rs2_data,         rs2d(e.pc));
        chk({tag, " ex_imm"},       ex_imm,              immd(e.pc));
        chk({tag, " ex_funct4"},    XLEN'(ex_funct4),    XLEN'(e.pc[5:2]));
        chk({tag, " ex_funct3"},    XLEN'(ex_funct3),    XLEN'(e.pc[4:2]));
        chk({tag, " ex_rd"},        XLEN'(ex_rd),        XLEN'(e.rd));
        chk({tag, " ex_rs1"},       XLEN'(ex_rs1),       XLEN'(e.rs1));
        chk({tag, " ex_rs2"},       XLEN'(ex_rs2),       XLEN'(e.rs2));
        chk({tag, " ex_ctrl"},      XLEN'(ex_ctrl),      XLEN'(e.ctrl));
        chk({tag, " bubble_count"}, XLEN'(bubble_count), XLEN'(e.cnt));
    endtask

    task automatic drive(input stim_t s);
        id_valid    = s.v;
        id_pc       = s.pc;
        id_rs1_data = rs1d(s.pc);
        id_rs2_data = rs2d(s.pc);
        id_imm      = immd(s.pc);
        id_funct4   = s.pc[5:2];
        id_funct3   = s.pc[4:2];
        id_rd       = s.rd;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_ctrl     = s.ctrl;
        flush       = s.fl;
        ex_stall    = s.st;
    endtask

    // Drive on the falling edge, check the comb output, then score after the rising edge
    task automatic step(input string tag, input stim_t s, input exp_t e);
        exp_t got;
        @(negedge clk);
        drive(s);
        #1;
        chk({tag, " hazard_stall"}, XLEN'(hazard_stall), XLEN'(s.hz));
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            got = sb.pop_front();
            chk_out(tag, got);
        end
    endtask

    exp_t zero_e;
    int   model_cnt;

    initial begin
        zero_e = '{1'b0, '0, '0, '0, '0, 8'h00, '0};

        //           v  pc      rd  rs1 rs2 ctrl   fl st hz   ev epc     erd ers1 ers2 ectrl  cnt
        tbl.push_back(row(1, 64'h100, 5,  1,  2, C_ADD, 0, 0, 0,  1, 64'h100, 5,  1,  2, C_ADD, 0));
        tbl.push_back(row(1, 64'h104, 5,  3,  4, C_LD,  0, 0, 0,  1, 64'h104, 5,  3,  4, C_LD,  0));
        tbl.push_back(row(1, 64'h108, 6,  5,  7, C_ADD, 0, 0, 1,  0, 64'h0,   0,  0,  0, 8'h00, 1));
        tbl.push_back(row(1, 64'h108, 6,  5,  7, C_ADD, 0, 0, 0,  1, 64'h108, 6,  5,  7, C_ADD, 1));
        tbl.push_back(row(1, 64'h10c, 0,  1,  2, C_LD,  0, 0, 0,  1, 64'h10c, 0,  1,  2, C_LD,  1));
        tbl.push_back(row(1, 64'h110, 7,  0,  0, C_ADD, 0, 0, 0,  1, 64'h110, 7,  0,  0, C_ADD, 1));
        tbl.push_back(row(1, 64'h114, 8,  1,  2, C_LD,  0, 0, 0,  1, 64'h114, 8,  1,  2, C_LD,  1));
        tbl.push_back(row(0, 64'h118, 9,  1,  8, C_ADD, 0, 0, 0,  0, 64'h118, 9,  1,  8, 8'h00, 1));
        tbl.push_back(row(1, 64'h11c, 10, 0,  0, C_LD,  0, 0, 0,  1, 64'h11c, 10, 0,  0, C_LD,  1));
        tbl.push_back(row(1, 64'h120, 1,  10, 0, C_ADD, 1, 1, 0,  0, 64'h0,   0,  0,  0, 8'h00, 1));
        tbl.push_back(row(1, 64'h124, 2,  1,  2, C_ADD, 0, 0, 0,  1, 64'h124, 2,  1,  2, C_ADD, 1));
        tbl.push_back(row(1, 64'h128, 3,  4,  5, C_LD,  0, 1, 1,  1, 64'h124, 2,  1,  2, C_ADD, 1));
        tbl.push_back(row(1, 64'h12c, 4,  6,  7, C_ADD, 0, 1, 1,  1, 64'h124, 2,  1,  2, C_ADD, 1));
        tbl.push_back(row(1, 64'h130, 5,  8,  9, C_LD,  0, 1, 1,  1, 64'h124, 2,  1,  2, C_ADD, 1));
        tbl.push_back(row(1, 64'h134, 3,  1,  2, C_LD,  0, 0, 0,  1, 64'h134, 3,  1,  2, C_LD,  1));
        tbl.push_back(row(1, 64'h138, 4,  3,  1, C_ADD, 0, 1, 1,  1, 64'h134, 3,  1,  2, C_LD,  1));
        tbl.push_back(row(1, 64'h138, 4,  3,  1, C_ADD, 0, 0, 1,  0, 64'h0,   0,  0,  0, 8'h00, 2));
        tbl.push_back(row(1, 64'h138, 4,  3,  1, C_ADD, 0, 0, 0,  1, 64'h138, 4,  3,  1, C_ADD, 2));
        tbl.push_back(row(1, 64'h13c, 4,  1,  2, C_LD,  0, 0, 0,  1, 64'h13c, 4,  1,  2, C_LD,  2));
        tbl.push_back(row(1, 64'h140, 5,  2,  4, C_ADD, 1, 0, 0,  0, 64'h0,   0,  0,  0, 8'h00, 2));

        // Reset state
        reset_n = 1'b0;
        drive('{1'b1, 64'h100, 5'd5, 5'd1, 5'd2, C_ADD, 1'b0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", zero_e);
        chk("reset hazard_stall", XLEN'(hazard_stall), '0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
        end

        // Saturation: five load-use bubbles on a 2-bit counter
        model_cnt = 2;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("sat%0d_ld", i),
                 '{1'b1, XLEN'(64'h200 + i * 8), 5'd5, 5'd1, 5'd2, C_LD, 1'b0, 1'b0, 1'b0},
                 '{1'b1, XLEN'(64'h200 + i * 8), 5'd5, 5'd1, 5'd2, C_LD, CNT_W'(model_cnt)});
            model_cnt = (model_cnt < 3) ? model_cnt + 1 : 3;
            step($sformatf("sat%0d_bub", i),
                 '{1'b1, 64'h300, 5'd6, 5'd1, 5'd5, C_ADD, 1'b0, 1'b0, 1'b1},
                 '{1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00, CNT_W'(model_cnt)});
        end
        chk("sat final bubble_count", XLEN'(bubble_count), XLEN'(3));

        // Asynchronous reset in the middle of a pending load-use bubble
        step("pre_rst_ld",
             '{1'b1, 64'h400, 5'd7, 5'd1, 5'd2, C_LD, 1'b0, 1'b0, 1'b0},
             '{1'b1, 64'h400, 5'd7, 5'd1, 5'd2, C_LD, 2'd3});
        @(negedge clk);
        drive('{1'b1, 64'h404, 5'd8, 5'd7, 5'd0, C_ADD, 1'b0, 1'b0, 1'b1});
        #1;
        chk("pre_rst hazard_stall", XLEN'(hazard_stall), XLEN'(1));
        #1;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", zero_e);
        chk("async_rst hazard_stall", XLEN'(hazard_stall), '0);
        @(posedge clk);
        #1;
        chk_out("rst_held", zero_e);
        @(negedge clk);
        reset_n = 1'b1;

        // First capture after reset takes the held consumer directly, no bubble
        step("post_rst",
             '{1'b1, 64'h404, 5'd8, 5'd7, 5'd0, C_ADD, 1'b0, 1'b0, 1'b0},
             '{1'b1, 64'h404, 5'd8, 5'd7, 5'd0, C_ADD, 2'd0});

        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
